// File: rtl/div_req_ctrl_pkg.sv
// rtl/div_req_ctrl_pkg.sv - shared types, width default and dout split helper for div_req_ctrl
package div_ctrl_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } div_state_e;

    typedef struct packed {
        logic [DIV_WIDTH_DEFAULT-1:0] q;
        logic [DIV_WIDTH_DEFAULT-1:0] r;
    } div_res_t;

    // The IP packs the quotient in the upper half and the remainder in the lower half.
    function automatic div_res_t div_split(input logic [2*DIV_WIDTH_DEFAULT-1:0] dout);
        div_res_t res;
        res.q = dout[2*DIV_WIDTH_DEFAULT-1:DIV_WIDTH_DEFAULT];
        res.r = dout[DIV_WIDTH_DEFAULT-1:0];
        return res;
    endfunction

endpackage

// File: rtl/div_req_ctrl_if.sv
// rtl/div_req_ctrl_if.sv - request/response port and divider IP AXIS channels for div_req_ctrl
interface div_req_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_signed;
    logic             req_rem;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_divz;

    logic             s_axis_divisor_tvalid;
    logic             s_axis_divisor_tready;
    logic [WIDTH-1:0] s_axis_divisor_tdata;
    logic             s_axis_dividend_tvalid;
    logic             s_axis_dividend_tready;
    logic [WIDTH-1:0] s_axis_dividend_tdata;

    logic               m_axis_dout_tvalid;
    logic [2*WIDTH-1:0] m_axis_dout_tdata;

    // Controller side
    modport slave (
        input  req_valid, req_signed, req_rem, req_a, req_b, rsp_ready,
        input  s_axis_divisor_tready, s_axis_dividend_tready,
        input  m_axis_dout_tvalid, m_axis_dout_tdata,
        output req_ready, rsp_valid, rsp_data, rsp_divz,
        output s_axis_divisor_tvalid, s_axis_divisor_tdata,
        output s_axis_dividend_tvalid, s_axis_dividend_tdata
    );

    // Execute stage plus divider IP side
    modport master (
        output req_valid, req_signed, req_rem, req_a, req_b, rsp_ready,
        output s_axis_divisor_tready, s_axis_dividend_tready,
        output m_axis_dout_tvalid, m_axis_dout_tdata,
        input  req_ready, rsp_valid, rsp_data, rsp_divz,
        input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
        input  s_axis_dividend_tvalid, s_axis_dividend_tdata
    );

endinterface

// File: rtl/div_req_ctrl_sign_fix.sv
// rtl/div_req_ctrl_sign_fix.sv - two-lane conditional two's complement negate (built only with DIV_SIGNED_EN)
`ifdef DIV_SIGNED_EN
module div_sign_fix
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic             neg_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             neg_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b
);

    // Negation wraps at WIDTH bits, so the most negative value maps to itself.
    always_comb begin
        out_a = neg_a ? (~in_a + {{(WIDTH-1){1'b0}}, 1'b1}) : in_a;
        out_b = neg_b ? (~in_b + {{(WIDTH-1){1'b0}}, 1'b1}) : in_b;
    end

endmodule
`endif

// File: rtl/div_req_ctrl.sv
// rtl/div_req_ctrl.sv - divider IP request/response controller; optional signed path under DIV_SIGNED_EN
module div_req_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic         aclk,
    input  logic         areset,
    div_req_ctrl_if.slave bus
);

    div_state_e       state;
    div_state_e       state_nxt;
    logic             rem_sel;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
    logic             divisor_hs;
    logic             dividend_hs;
    div_res_t         split;

    assign split       = div_split(bus.m_axis_dout_tdata);
    assign divisor_hs  = bus.s_axis_divisor_tvalid & bus.s_axis_divisor_tready;
    assign dividend_hs = bus.s_axis_dividend_tvalid & bus.s_axis_dividend_tready;

`ifdef DIV_SIGNED_EN
    logic neg_a_in;
    logic neg_b_in;
    logic neg_q;
    logic neg_r;

    assign neg_a_in = bus.req_signed & bus.req_a[WIDTH-1];
    assign neg_b_in = bus.req_signed & bus.req_b[WIDTH-1];

    div_sign_fix #(.WIDTH(WIDTH)) u_operand_fix (
        .in_a  (bus.req_a),
        .neg_a (neg_a_in),
        .in_b  (bus.req_b),
        .neg_b (neg_b_in),
        .out_a (mag_a),
        .out_b (mag_b)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
        .in_a  (split.q),
        .neg_a (neg_q),
        .in_b  (split.r),
        .neg_b (neg_r),
        .out_a (fix_q),
        .out_b (fix_r)
    );

    // Result signs: quotient negative when operand signs differ, remainder follows the dividend.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == ST_IDLE && bus.req_valid) begin
            neg_q <= neg_a_in ^ neg_b_in;
            neg_r <= neg_a_in;
        end
    end
`else
    logic unused_req_signed;

    assign unused_req_signed = bus.req_signed;
    assign mag_a             = bus.req_a;
    assign mag_b             = bus.req_b;
    assign fix_q             = split.q;
    assign fix_r             = split.r;
`endif

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: ISSUE waits for both operand channels, each of which may complete in any order.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt = (bus.req_b == '0) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if ((!bus.s_axis_divisor_tvalid || divisor_hs) &&
                    (!bus.s_axis_dividend_tvalid || dividend_hs)) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.m_axis_dout_tvalid) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; req_ready is forced low while reset is held.
    always_comb begin
        bus.req_ready = (state == ST_IDLE) && !areset;
        bus.rsp_valid = (state == ST_RESP);
    end

    // Operand channels: both raised on accept, each dropped after its own handshake, tdata frozen meanwhile.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bus.s_axis_divisor_tvalid  <= 1'b0;
            bus.s_axis_divisor_tdata   <= '0;
            bus.s_axis_dividend_tvalid <= 1'b0;
            bus.s_axis_dividend_tdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && bus.req_b != '0) begin
                        bus.s_axis_divisor_tvalid  <= 1'b1;
                        bus.s_axis_divisor_tdata   <= mag_b;
                        bus.s_axis_dividend_tvalid <= 1'b1;
                        bus.s_axis_dividend_tdata  <= mag_a;
                    end
                end
                ST_ISSUE: begin
                    if (divisor_hs) begin
                        bus.s_axis_divisor_tvalid <= 1'b0;
                    end
                    if (dividend_hs) begin
                        bus.s_axis_dividend_tvalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response register: divide-by-zero result is formed at accept, IP results only while in WAIT.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rem_sel      <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_divz <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        rem_sel <= bus.req_rem;
                        if (bus.req_b == '0) begin
                            bus.rsp_data <= bus.req_rem ? bus.req_a : '1;
                            bus.rsp_divz <= 1'b1;
                        end else begin
                            bus.rsp_divz <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.m_axis_dout_tvalid) begin
                        bus.rsp_data <= rem_sel ? fix_r : fix_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_req_ctrl.sv
// tb/tb_div_req_ctrl.sv - self-checking bench for div_req_ctrl with a behavioural divider IP
module tb_div_req_ctrl;

`ifdef DIV_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic aclk;
    logic areset;
    int   n_vec;
    int   n_err;

    int   ip_dv_hold;
    int   ip_dd_hold;
    int   ip_lat;

    div_req_ctrl_if #(.WIDTH(32)) bus ();

    div_req_ctrl #(.WIDTH(32)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        sgn;
        logic        rem;
        logic [31:0] a;
        logic [31:0] b;
        int          dvh;
        int          ddh;
        int          rh;
        logic [31:0] exp_data;
        logic        exp_divz;
        int          exp_dv_hi;
        int          exp_dd_hi;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected result from the arithmetic definition of truncating division.
    function automatic logic [32:0] ref_div(input logic sgn, input logic rem,
                                            input logic [31:0] a, input logic [31:0] b);
        longint na;
        longint nb;
        longint q;
        longint r;
        if (b == 32'd0) return {1'b1, rem ? a : 32'hFFFF_FFFF};
        if (SEN && sgn) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {1'b0, rem ? r[31:0] : q[31:0]};
    endfunction

    // Behavioural unsigned divider IP: per-channel tready delay, fixed latency, single dout beat.
    initial begin
        logic [31:0] cap_dv;
        logic [31:0] cap_dd;
        int          dv_wait;
        int          dd_wait;
        bit          got_dv;
        bit          got_dd;
        bit          pending;
        int          lat_cnt;
        cap_dv  = 32'd1;
        cap_dd  = 32'd0;
        dv_wait = 0;
        dd_wait = 0;
        got_dv  = 1'b0;
        got_dd  = 1'b0;
        pending = 1'b0;
        lat_cnt = 0;
        bus.s_axis_divisor_tready  = 1'b0;
        bus.s_axis_dividend_tready = 1'b0;
        bus.m_axis_dout_tvalid     = 1'b0;
        bus.m_axis_dout_tdata      = 64'd0;
        forever begin
            @(negedge aclk);
            bus.m_axis_dout_tvalid = 1'b0;
            if (pending) begin
                if (lat_cnt == 0) begin
                    bus.m_axis_dout_tvalid = 1'b1;
                    bus.m_axis_dout_tdata  = {cap_dd / cap_dv, cap_dd % cap_dv};
                    pending = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            if (bus.s_axis_divisor_tready) begin
                bus.s_axis_divisor_tready = 1'b0;
                got_dv  = 1'b1;
                dv_wait = 0;
            end else if (bus.s_axis_divisor_tvalid) begin
                if (dv_wait >= ip_dv_hold) begin
                    bus.s_axis_divisor_tready = 1'b1;
                    cap_dv = bus.s_axis_divisor_tdata;
                end else begin
                    dv_wait++;
                end
            end
            if (bus.s_axis_dividend_tready) begin
                bus.s_axis_dividend_tready = 1'b0;
                got_dd  = 1'b1;
                dd_wait = 0;
            end else if (bus.s_axis_dividend_tvalid) begin
                if (dd_wait >= ip_dd_hold) begin
                    bus.s_axis_dividend_tready = 1'b1;
                    cap_dd = bus.s_axis_dividend_tdata;
                end else begin
                    dd_wait++;
                end
            end
            if (got_dv && got_dd) begin
                got_dv  = 1'b0;
                got_dd  = 1'b0;
                pending = 1'b1;
                lat_cnt = ip_lat;
            end
        end
    end

    // One full request/response transaction, observed at falling edges.
    task automatic run_op(input logic sgn, input logic rem, input logic [31:0] a, input logic [31:0] b,
                          input int dvh, input int ddh, input int rh, input int lat_ip,
                          output logic [31:0] data, output logic divz, output int lat,
                          output int dv_hi, output int dd_hi,
                          output logic ok_td, output logic ok_hold, output logic ok_to);
        logic [31:0] exp_dv;
        logic [31:0] exp_dd;
        exp_dv  = (SEN && sgn && b[31]) ? (~b + 32'd1) : b;
        exp_dd  = (SEN && sgn && a[31]) ? (~a + 32'd1) : a;
        ok_td   = 1'b1;
        ok_hold = 1'b1;
        ok_to   = 1'b1;
        dv_hi   = 0;
        dd_hi   = 0;
        data    = 32'd0;
        divz    = 1'b0;
        ip_dv_hold = dvh;
        ip_dd_hold = ddh;
        ip_lat     = lat_ip;
        @(negedge aclk);
        if (bus.req_ready !== 1'b1) ok_hold = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_signed = sgn;
        bus.req_rem    = rem;
        bus.req_a      = a;
        bus.req_b      = b;
        @(negedge aclk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            if (bus.s_axis_divisor_tvalid) begin
                dv_hi++;
                if (bus.s_axis_divisor_tdata !== exp_dv) ok_td = 1'b0;
            end
            if (bus.s_axis_dividend_tvalid) begin
                dd_hi++;
                if (bus.s_axis_dividend_tdata !== exp_dd) ok_td = 1'b0;
            end
            @(negedge aclk);
            lat++;
        end
        if (!bus.rsp_valid) begin
            ok_to = 1'b0;
            return;
        end
        data = bus.rsp_data;
        divz = bus.rsp_divz;
        if (bus.req_ready !== 1'b0) ok_hold = 1'b0;
        repeat (rh) begin
            @(negedge aclk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== data || bus.req_ready !== 1'b0) ok_hold = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge aclk);
        bus.rsp_ready = 1'b0;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) ok_hold = 1'b0;
    endtask

    vec_t        vt[9];
    logic [31:0] r_data;
    logic        r_divz;
    int          r_lat;
    int          r_dv;
    int          r_dd;
    logic        r_td;
    logic        r_hold;
    logic        r_to;
    logic [32:0] exp;
    bit          stale_seen;
    bit          rsp_leak;

    initial begin
        n_vec = 0;
        n_err = 0;
        ip_dv_hold = 0;
        ip_dd_hold = 0;
        ip_lat     = 0;
        areset = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_rem    = 1'b0;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.rsp_ready  = 1'b0;

        vt[0] = '{1'b0, 1'b0, 32'h0000_2222, 32'h0000_0011, 0, 0, 0, 32'h0000_0202, 1'b0, 1, 1};
        vt[1] = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0,
                  SEN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 1'b0, 1, 1};
        vt[2] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1, 2, 1,
                  SEN ? 32'hFFFF_FFFF : 32'h0000_0001, 1'b0, 2, 3};
        vt[3] = '{1'b0, 1'b0, 32'h0000_0005, 32'h0000_0000, 0, 0, 0, 32'hFFFF_FFFF, 1'b1, 0, 0};
        vt[4] = '{1'b0, 1'b1, 32'h0000_0005, 32'h0000_0000, 0, 0, 0, 32'h0000_0005, 1'b1, 0, 0};
        vt[5] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0,
                  SEN ? 32'h8000_0000 : 32'h0000_0000, 1'b0, 1, 1};
        vt[6] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0,
                  SEN ? 32'h0000_0000 : 32'h8000_0000, 1'b0, 1, 1};
        vt[7] = '{1'b0, 1'b0, 32'd1000, 32'd10, 3, 0, 0, 32'd100, 1'b0, 4, 1};
        vt[8] = '{1'b0, 1'b1, 32'd1000, 32'd7, 0, 0, 5, 32'd6, 1'b0, 1, 1};

        #12;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_divz", {31'd0, bus.rsp_divz}, 32'd0);
        chk("rst_tvalids", {30'd0, bus.s_axis_divisor_tvalid, bus.s_axis_dividend_tvalid}, 32'd0);
        chk("rst_divisor_tdata", bus.s_axis_divisor_tdata, 32'd0);
        chk("rst_dividend_tdata", bus.s_axis_dividend_tdata, 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        chk("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_op(vt[i].sgn, vt[i].rem, vt[i].a, vt[i].b, vt[i].dvh, vt[i].ddh, vt[i].rh, 2,
                   r_data, r_divz, r_lat, r_dv, r_dd, r_td, r_hold, r_to);
            chk($sformatf("vec%0d_timeout", i), {31'd0, r_to}, 32'd1);
            chk($sformatf("vec%0d_data", i), r_data, vt[i].exp_data);
            chk($sformatf("vec%0d_divz", i), {31'd0, r_divz}, {31'd0, vt[i].exp_divz});
            chk($sformatf("vec%0d_tdata", i), {31'd0, r_td}, 32'd1);
            chk($sformatf("vec%0d_hold", i), {31'd0, r_hold}, 32'd1);
            chk($sformatf("vec%0d_divisor_cycles", i), r_dv, vt[i].exp_dv_hi);
            chk($sformatf("vec%0d_dividend_cycles", i), r_dd, vt[i].exp_dd_hi);
            if (vt[i].exp_divz) chk($sformatf("vec%0d_divz_latency", i), r_lat, 1);
        end

        // Reset pulsed in WAIT: the abandoned op's dout beat must not produce a response.
        ip_dv_hold = 0;
        ip_dd_hold = 0;
        ip_lat     = 6;
        @(negedge aclk);
        bus.req_valid = 1'b1;
        bus.req_signed = 1'b0;
        bus.req_rem = 1'b0;
        bus.req_a = 32'd50;
        bus.req_b = 32'd3;
        @(negedge aclk);
        bus.req_valid = 1'b0;
        @(negedge aclk);
        chk("wait_tvalids_low", {30'd0, bus.s_axis_divisor_tvalid, bus.s_axis_dividend_tvalid}, 32'd0);
        #1 areset = 1'b1;
        #1;
        chk("async_rsp_data", bus.rsp_data, 32'd0);
        chk("async_req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        stale_seen = 1'b0;
        rsp_leak   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            if (bus.m_axis_dout_tvalid) stale_seen = 1'b1;
            if (bus.rsp_valid) rsp_leak = 1'b1;
        end
        chk("stale_beat_seen", {31'd0, stale_seen}, 32'd1);
        chk("stale_beat_ignored", {31'd0, rsp_leak}, 32'd0);
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 0, 0, 0, 2, r_data, r_divz, r_lat, r_dv, r_dd, r_td, r_hold, r_to);
        chk("after_rst_timeout", {31'd0, r_to}, 32'd1);
        chk("after_rst_data", r_data, 32'd2);
        chk("after_rst_divz", {31'd0, r_divz}, 32'd0);

        // Randomised operations against the arithmetic model.
        for (int n = 0; n < 150; n++) begin
            logic        sgn;
            logic        rem;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            sgn = 1'($urandom_range(0, 1));
            rem = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel < 4) begin
                b = 32'($urandom_range(1, 20));
                if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
            end else b = $urandom;
            exp = ref_div(sgn, rem, a, b);
            run_op(sgn, rem, a, b, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 4), r_data, r_divz, r_lat, r_dv, r_dd, r_td, r_hold, r_to);
            chk($sformatf("rnd%0d_timeout", n), {31'd0, r_to}, 32'd1);
            chk($sformatf("rnd%0d_data a=%h b=%h s=%0d rem=%0d", n, a, b, sgn, rem), r_data, exp[31:0]);
            chk($sformatf("rnd%0d_divz", n), {31'd0, r_divz}, {31'd0, exp[32]});
            chk($sformatf("rnd%0d_tdata", n), {31'd0, r_td}, 32'd1);
            chk($sformatf("rnd%0d_hold", n), {31'd0, r_hold}, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
